// File: rtl/siso_shift_reg_param.sv
// rtl/siso_shift_reg_param.sv - multi-mode DEPTH x WIDTH shift register with frame counter
module siso_shift_reg_param #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       si_r,
  input  logic [WIDTH-1:0]       si_l,
  input  logic [DEPTH*WIDTH-1:0] pdata,
  output logic [WIDTH-1:0]       q_r,
  output logic [WIDTH-1:0]       q_l,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [CW-1:0]          cnt,
  output logic                   done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  logic [WIDTH-1:0] stage     [DEPTH];
  logic [WIDTH-1:0] stage_nxt [DEPTH];
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             shift;

  always_comb begin
    stage_nxt = stage;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    shift     = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt[i] = '0;
      cnt_nxt = '0;
    end else begin
      case (mode)
        MODE_RIGHT: begin
          shift = 1'b1;
          for (int i = 0; i < DEPTH - 1; i++) stage_nxt[i] = stage[i+1];
          stage_nxt[DEPTH-1] = si_r;
        end
        MODE_LEFT: begin
          shift = 1'b1;
          for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
          stage_nxt[0] = si_l;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) stage_nxt[i] = pdata[i*WIDTH +: WIDTH];
          cnt_nxt = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
      // Counter saturates at DEPTH so done fires once per frame, never while parked.
      if (shift && (cnt != CNT_FULL)) begin
        cnt_nxt  = cnt + CW'(1);
        done_nxt = (cnt == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= stage_nxt[i];
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

  assign q_r = stage[0];
  assign q_l = stage[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_pout
    assign pout[g*WIDTH +: WIDTH] = stage[g];
  end

endmodule
